// File: rtl/arbiter_mux_if.sv
// +--------------------------------------------------------------------------+
// | arbiter_mux_if : actor-side, arbiter-side and output-stream signals      |
// |                  shared by arbiter_mux and whoever drives it.            |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

interface arbiter_mux_if #(
   parameter int NUM_PORTS  = 6,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
   logic [0:NUM_PORTS-1]            in_valid;
   logic [0:NUM_PORTS-1]            in_last;
   logic [0:NUM_PORTS-1]            in_ready;
   logic [0:NUM_PORTS-1]            request;
   logic [0:NUM_PORTS-1]            grant;
   logic                            active;
   logic [DATA_WIDTH-1:0]           out_data;
   logic                            out_last;
   logic                            out_valid;
   logic                            out_ready;
   logic                            timeout;

   modport master (
      output in_data, in_valid, in_last, grant, active, out_ready,
      input  in_ready, request, out_data, out_last, out_valid, timeout
   );

   modport slave (
      input  in_data, in_valid, in_last, grant, active, out_ready,
      output in_ready, request, out_data, out_last, out_valid, timeout
   );
endinterface

`default_nettype wire

// File: rtl/arbiter_mux.sv
// +--------------------------------------------------------------------------+
// | arbiter_mux : forwards whole packets from the arbiter's winning actor    |
// |               onto one stream through a 2-entry skid buffer.             |
// | Option      : ARBITER_MUX_TIMEOUT_EN adds a stall-release timeout.       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module arbiter_mux #(
   parameter int NUM_PORTS      = 6,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic         clk,
   input  logic         rst,
   arbiter_mux_if.slave bus
);
   localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
      $error("arbiter_mux: TIMEOUT_CYCLES must be 1..65535");
   end

   state_t                state_q, state_d;
   logic [OW-1:0]         owner_q, owner_d;
   logic [DATA_WIDTH:0]   mem_q [2];
   logic [DATA_WIDTH:0]   mem_d [2];
   logic                  rd_ptr_q, rd_ptr_d;
   logic                  wr_ptr_q, wr_ptr_d;
   logic [1:0]            count_q, count_d;
`ifdef ARBITER_MUX_TIMEOUT_EN
   logic [15:0]           tmo_cnt_q, tmo_cnt_d;
   logic                  timeout_q, timeout_d;
`endif

   logic [0:NUM_PORTS-1]  owner_oh;
   logic                  own_valid;
   logic                  own_last;
   logic [DATA_WIDTH-1:0] own_data;
   logic                  gnt_hit;
   logic [OW-1:0]         gnt_idx;
   logic                  push;
   logic                  pop;

   always_comb begin
      owner_oh  = '0;
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_data  = '0;
      gnt_hit   = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (owner_q == OW'(i)) begin
            owner_oh[i] = 1'b1;
            own_valid   = bus.in_valid[i];
            own_last    = bus.in_last[i];
            own_data    = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
         if (bus.grant[i] && bus.in_valid[i]) begin
            gnt_hit = bus.active;
            gnt_idx = OW'(i);
         end
      end
   end

   assign push = (state_q == S_BUSY) && own_valid && (count_q != 2'd2);
   assign pop  = (count_q != 2'd0) && bus.out_ready;

   // Request/ready are combinational so the arbiter sees them in the same cycle;
   // they are forced low while reset is asserted.
   always_comb begin
      bus.request  = '0;
      bus.in_ready = '0;
      if (!rst) begin
         case (state_q)
            S_IDLE:    bus.request = bus.in_valid;
            S_BUSY: begin
               bus.request  = bus.in_valid | owner_oh;
               bus.in_ready = (count_q != 2'd2) ? owner_oh : '0;
            end
            S_RELEASE: bus.request = bus.in_valid & ~owner_oh;
            default:   bus.request = '0;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
`ifdef ARBITER_MUX_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (gnt_hit) begin
               owner_d = gnt_idx;
               state_d = S_BUSY;
`ifdef ARBITER_MUX_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         S_BUSY: begin
            if (push && own_last) begin
               state_d = S_RELEASE;
            end
`ifdef ARBITER_MUX_TIMEOUT_EN
            else if (push) begin
               tmo_cnt_d = '0;
            end else if (!own_valid) begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
               if (tmo_cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
                  state_d   = S_RELEASE;
                  timeout_d = 1'b1;
               end
            end
`endif
         end
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {own_last, own_data};
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         owner_q  <= '0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
`ifdef ARBITER_MUX_TIMEOUT_EN
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
`ifdef ARBITER_MUX_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign bus.out_valid = (count_q != 2'd0);
   assign {bus.out_last, bus.out_data} = mem_q[rd_ptr_q];
`ifdef ARBITER_MUX_TIMEOUT_EN
   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arbiter_mux.sv
// +--------------------------------------------------------------------------+
// | tb_arbiter_mux : directed bench for arbiter_mux with a round-robin       |
// |                  arbiter model driving grant/active.                     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_arbiter_mux;
   localparam int NP = 6;
   localparam int DW = 32;
`ifdef ARBITER_MUX_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 64;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   arbiter_mux_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

   arbiter_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Round-robin arbiter model: registered grant, held while the holder requests.
   int              arb_last;
   int              arb_pick;
   logic [0:NP-1]   arb_oh;

   function automatic int rr_pick(input logic [0:NP-1] req, input int last);
      for (int k = 1; k <= NP; k++) begin
         if (req[(last + k) % NP]) return (last + k) % NP;
      end
      return -1;
   endfunction

   always_comb begin
      arb_pick = rr_pick(bus.request, arb_last);
      arb_oh   = '0;
      if (arb_pick >= 0) arb_oh[arb_pick] = 1'b1;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.grant  <= '0;
         bus.active <= 1'b0;
         arb_last   <= NP - 1;
      end else if (!(bus.active && ((bus.request & bus.grant) != '0))) begin
         bus.grant  <= arb_oh;
         bus.active <= (arb_pick >= 0);
         if (arb_pick >= 0) arb_last <= arb_pick;
      end
   end

   logic [DW-1:0]  src_data [NP][16];
   logic           src_last [NP][16];
   int             src_len  [NP];
   int             src_idx  [NP];
   logic [0:NP-1]  acc;
   logic           or_plan;
   logic [DW:0]    got[$];
   logic [DW:0]    exp_q[$];
   int             acc_port[$];
   int             acc_cyc[$];
   logic [0:NP-1]  h_req [512];
   logic [0:NP-1]  h_ird [512];
   logic           h_ov  [512];
   int             cyc;
   int             n_pass;
   int             n_checks;
   logic           tmo_seen;
   logic           tmo_any;
   int             tmo_cyc;
   int             c0;
   logic           seen;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic load(input int p, input logic [DW-1:0] d, input logic l);
      src_data[p][src_len[p]] = d;
      src_last[p][src_len[p]] = l;
      src_len[p]++;
   endtask

   function automatic int acc_cyc_at(input int i);
      return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
   endfunction

   function automatic int acc_port_at(input int i);
      return (i < acc_port.size()) ? acc_port[i] : -1;
   endfunction

   task automatic tick();
      @(negedge clk);
      bus.out_ready = or_plan;
      for (int p = 0; p < NP; p++) begin
         if (acc[p]) src_idx[p]++;
         if (src_idx[p] < src_len[p]) begin
            bus.in_valid[p]            = 1'b1;
            bus.in_data[p*DW +: DW]    = src_data[p][src_idx[p]];
            bus.in_last[p]             = src_last[p][src_idx[p]];
         end else begin
            bus.in_valid[p] = 1'b0;
            bus.in_last[p]  = 1'b0;
         end
      end
      #4;
      h_req[cyc] = bus.request;
      h_ird[cyc] = bus.in_ready;
      h_ov[cyc]  = bus.out_valid;
      for (int p = 0; p < NP; p++) begin
         acc[p] = bus.in_valid[p] & bus.in_ready[p];
         if (acc[p]) begin
            acc_port.push_back(p);
            acc_cyc.push_back(cyc);
         end
      end
      if (bus.out_valid && bus.out_ready) got.push_back({bus.out_last, bus.out_data});
      if (bus.timeout) begin
         tmo_seen = 1'b1;
         tmo_any  = 1'b1;
         tmo_cyc  = cyc;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = '0;
      bus.in_last   = '0;
      bus.in_data   = '0;
      or_plan       = 1'b1;
      bus.out_ready = 1'b1;
      acc           = '0;
      for (int p = 0; p < NP; p++) begin
         src_len[p] = 0;
         src_idx[p] = 0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      got.delete();
      acc_port.delete();
      acc_cyc.delete();
      tmo_seen = 1'b0;
   endtask

   task automatic chk_stream(input string tag);
      chk({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("%s_beat%0d", tag, i), (i < got.size()) ? 64'(got[i]) : 'x, 64'(exp_q[i]));
      end
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_pass = 0; n_checks = 0; cyc = 0; tmo_any = 1'b0; tmo_seen = 1'b0; tmo_cyc = -1;
      rst = 1'b0;
      bus.in_valid = '0; bus.in_last = '0; bus.in_data = '0;
      bus.out_ready = 1'b1; or_plan = 1'b1; acc = '0;
      for (int p = 0; p < NP; p++) begin src_len[p] = 0; src_idx[p] = 0; end
      #1 rst = 1'b1;
      bus.in_valid = 6'b111111;
      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
      chk("rst_request",   64'(bus.request),   64'd0);
      chk("rst_timeout",   64'(bus.timeout),   64'd0);
      chk("rst_out_data",  64'({bus.out_last, bus.out_data}), 64'd0);

      // Test 1: 3-beat packet from port 0, then a 1-beat packet.
      do_reset();
      load(0, 32'hD000_0000, 1'b0); load(0, 32'hD000_0001, 1'b0);
      load(0, 32'hD000_0002, 1'b1); load(0, 32'hE000_0000, 1'b1);
      c0 = cyc;
      repeat (14) tick();
      chk("t1_req_cycle0",  64'(h_req[c0][0]),   64'd1);
      chk("t1_ov_before",   64'(h_ov[c0+2]),     64'd0);
      chk("t1_ov_first",    64'(h_ov[c0+3]),     64'd1);
      chk("t1_d0_acc_cyc",  64'(acc_cyc_at(0)),  64'(c0+2));
      chk("t1_d2_acc_cyc",  64'(acc_cyc_at(2)),  64'(c0+4));
      chk("t1_req_busy",    64'(h_req[c0+4][0]), 64'd1);
      chk("t1_req_release", 64'(h_req[c0+5][0]), 64'd0);
      chk("t1_req_after",   64'(h_req[c0+6][0]), 64'd1);
      exp_q = '{{1'b0, 32'hD000_0000}, {1'b0, 32'hD000_0001}, {1'b1, 32'hD000_0002}, {1'b1, 32'hE000_0000}};
      chk_stream("t1");

      // Test 2: ports 0 and 2 contend; no interleave.
      do_reset();
      load(0, 32'hA000_0000, 1'b0); load(0, 32'hA000_0001, 1'b1);
      load(2, 32'hB000_0000, 1'b0); load(2, 32'hB000_0001, 1'b1);
      c0 = cyc;
      repeat (14) tick();
      seen = 1'b0;
      for (int k = 0; k < 6; k++) seen |= h_ird[c0+k][2];
      chk("t2_ird2_early",    64'(seen),            64'd0);
      chk("t2_ird2_first",    64'(h_ird[c0+6][2]),  64'd1);
      chk("t2_ird0_release",  64'(h_ird[c0+4][0]),  64'd0);
      chk("t2_b0_acc_cyc",    64'(acc_cyc_at(2)),   64'(c0+6));
      exp_q = '{{1'b0, 32'hA000_0000}, {1'b1, 32'hA000_0001}, {1'b0, 32'hB000_0000}, {1'b1, 32'hB000_0001}};
      chk_stream("t2");

      // Test 3: backpressure fills the skid buffer.
      do_reset();
      for (int k = 0; k < 6; k++) load(1, 32'hC000_0000 + k, (k == 5));
      c0 = cyc;
      or_plan = 1'b1; repeat (5) tick();
      or_plan = 1'b0; repeat (5) tick();
      or_plan = 1'b1; repeat (12) tick();
      chk("t3_ird_not_full", 64'(h_ird[c0+5][1]),  64'd1);
      chk("t3_ird_full_a",   64'(h_ird[c0+6][1]),  64'd0);
      chk("t3_ird_full_b",   64'(h_ird[c0+9][1]),  64'd0);
      chk("t3_ov_full",      64'(h_ov[c0+9]),      64'd1);
      chk("t3_ird_resume",   64'(h_ird[c0+11][1]), 64'd1);
      for (int k = 0; k < 6; k++) exp_q.push_back({(k == 5), 32'hC000_0000 + k});
      chk_stream("t3");

      // Test 4: back-to-back 1-beat packets from ports 1 and 3.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         load(1, 32'h1100_0000 + k, 1'b1);
         load(3, 32'h3300_0000 + k, 1'b1);
      end
      c0 = cyc;
      repeat (22) tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t4_port%0d", k),  64'(acc_port_at(k)), 64'((k % 2 == 0) ? 1 : 3));
         chk($sformatf("t4_cycle%0d", k), 64'(acc_cyc_at(k)),  64'(c0 + 2 + 3*k));
      end
      chk("t4_release_req1", 64'(h_req[c0+3][1]), 64'd0);
      chk("t4_release_req3", 64'(h_req[c0+3][3]), 64'd1);
      for (int k = 0; k < 3; k++) begin
         exp_q.push_back({1'b1, 32'h1100_0000 + k});
         exp_q.push_back({1'b1, 32'h3300_0000 + k});
      end
      chk_stream("t4");

      // Test 5: reset in the middle of a packet.
      do_reset();
      for (int k = 0; k < 4; k++) load(3, 32'h5500_0000 + k, (k == 3));
      c0 = cyc;
      repeat (4) tick();
      chk("t5_acc_two", 64'(acc_port.size()), 64'd2);
      @(negedge clk);
      chk("t5_ov_pre", 64'(bus.out_valid), 64'd1);
      #1 rst = 1'b1;
      #3;
      chk("t5_ov_rst",  64'(bus.out_valid), 64'd0);
      chk("t5_ird_rst", 64'(bus.in_ready),  64'd0);
      chk("t5_req_rst", 64'(bus.request),   64'd0);
      do_reset();
      for (int k = 0; k < 3; k++) load(4, 32'h4400_0000 + k, (k == 2));
      repeat (12) tick();
      for (int k = 0; k < 3; k++) exp_q.push_back({(k == 2), 32'h4400_0000 + k});
      chk_stream("t5");

`ifdef ARBITER_MUX_TIMEOUT_EN
      // Test 6: port 2 stalls mid-packet, port 5 waits.
      do_reset();
      load(2, 32'h2200_0000, 1'b0);
      load(5, 32'h5500_00AA, 1'b1);
      repeat (24) tick();
      chk("t6_first_port",  64'(acc_port_at(0)), 64'd2);
      chk("t6_tmo_seen",    64'(tmo_seen),       64'd1);
      chk("t6_tmo_cycle",   64'(tmo_cyc),        64'(acc_cyc_at(0) + 9));
      chk("t6_second_port", 64'(acc_port_at(1)), 64'd5);
      chk("t6_second_cyc",  64'(acc_cyc_at(1)),  64'(acc_cyc_at(0) + 11));
      exp_q = '{{1'b0, 32'h2200_0000}, {1'b1, 32'h5500_00AA}};
      chk_stream("t6");
`else
      chk("timeout_never", 64'(tmo_any), 64'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/arbiter_mux.md
Name: arbiter_mux

Overview:
- Packet multiplexer that sits directly downstream of the round-robin arbiter and also drives that arbiter's request inputs.
- Collects valid/ready packet streams from NUM_PORTS actors and raises their arbiter requests.
- Consumes the arbiter's registered grant/active outputs and forwards the winning actor's whole packet onto one shared output stream.
- Packets are never interleaved; the output stage is a 2-entry skid buffer.

Parameters:
- NUM_PORTS, 6, number of actors; must equal the arbiter's NUM_PORTS.
- DATA_WIDTH, 32, beat width in bits.
- TIMEOUT_CYCLES, 64, stall limit used only when ARBITER_MUX_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  NUM_PORTS*DATA_WIDTH  port i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  [0:NUM_PORTS-1]  per-port beat valid.
- in_last  input  [0:NUM_PORTS-1]  per-port final beat of packet.
- in_ready  output  [0:NUM_PORTS-1]  per-port beat accepted when valid&ready.
- request  output  [0:NUM_PORTS-1]  to arbiter request; bit i = port i.
- grant  input  [0:NUM_PORTS-1]  from arbiter grant; registered, one-hot or zero.
- active  input  1  from arbiter active.
- out_data  output  DATA_WIDTH  shared stream data.
- out_last  output  1  shared stream last.
- out_valid  output  1  shared stream valid.
- out_ready  input  1  shared stream ready.
- timeout  output  1  one-cycle pulse on forced release; constant 0 without the macro.

Behaviour:
- Reset (async, any time, including mid-packet):
  - State goes to IDLE, owner clears and the skid buffer empties; buffered beats are discarded.
  - out_valid, out_data, out_last, in_ready, request and timeout are all 0.
- Input rule: in_valid, once high, must hold with stable data/last until accepted. The block is not required to tolerate violations.
- States:
  - IDLE: request = in_valid; in_ready = 0. If active=1 and grant[i]=1 with in_valid[i]=1, latch owner=i and go to BUSY next cycle. Ignore grant with no matching in_valid.
  - BUSY: request = in_valid | onehot(owner), so the owner's request is held high for the whole packet even through valid gaps. in_ready[owner] = (buffer count < 2); all other in_ready bits are 0. When in_valid[owner] & in_ready[owner] & in_last[owner], go to RELEASE.
  - RELEASE: lasts exactly one cycle. request = in_valid with the owner's bit forced 0. in_ready = 0. Grant is ignored, because it still shows the old owner due to the arbiter's one-cycle register. Then go to IDLE.
- Latency:
  - request rises in cycle 0, grant appears after edge 1, owner latches at edge 2, and the first beat is accepted at edge 3.
  - out_valid is high after edge 3; this is the earliest first output beat.
- Throughput: 1 beat/cycle while out_ready=1.
- Skid buffer:
  - FIFO of {data,last}, depth 2.
  - out_valid = count != 0; out_data/out_last come from the head entry.
  - Simultaneous push and pop with count=2 cannot occur, since in_ready is 0 at count=2.
  - Push and pop at count=1 leaves count=1 with order preserved.
- Re-grant: a port that finished a packet may be granted again only if it is still requesting after RELEASE. Arbiter round-robin order decides.
- Single-beat packet (last on the first beat) is legal: IDLE→BUSY→RELEASE.
- out_data holds its last value when out_valid=0; verification must not check out_data while out_valid=0.

Optional Feature:
- Macro ARBITER_MUX_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and on every accepted owner beat.
  - It increments on each BUSY cycle with in_valid[owner]=0.
  - On reaching TIMEOUT_CYCLES, go to RELEASE and pulse timeout for 1 cycle.
  - out_last is not synthesized for the truncated packet.
- Undefined: no counter logic; timeout tied 0; BUSY exits only on last.

Test Plan:
1. Port 0 sends 3-beat packet D0,D1,D2, out_ready=1 → out beats D0,D1,D2 in order; out_last with D2 only; first out_valid 3 cycles after in_valid rose; request[0] low for exactly 1 cycle after the D2 handshake.
2. Ports 0 and 2 valid together, 2-beat packets A0,A1 / B0,B1 → output A0,A1,B0,B1 with no interleave; in_ready[2] stays 0 until port 0 RELEASE.
3. Port 1 sends 6 beats; out_ready low for 5 cycles after beat 2 → count saturates at 2; in_ready[1]=0 while full; all 6 beats delivered once, in order.
4. Ports 1 and 3 each send back-to-back 1-beat packets continuously → grant order 1,3,1,3; one RELEASE cycle between packets.
5. rst asserted mid-packet (after 2 of 4 beats) → out_valid, in_ready and request are 0 in the same cycle as rst, before the next clk edge; after rst deasserts, a new packet from port 4 is delivered intact.
6. With ARBITER_MUX_TIMEOUT_EN and TIMEOUT_CYCLES=8, port 2 sends 1 beat and then drops valid → timeout pulses 8 BUSY cycles after the last accepted beat; port 5, pending throughout, is granted afterwards.
